// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the single register-file read port among NUM_REQ requesters.
// Two-stage pipeline: grant/capture, then read with r0/writeback resolution, then response.
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [5*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 port_block,
    output logic [4:0]           rf_read_addr,
    input  logic [DATA_W-1:0]    rf_read_data,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [DATA_W-1:0]    resp_data
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]     r_rr_ptr;
    logic               r_s1_v;
    logic [4:0]         r_s1_addr;
    logic [IDW-1:0]     r_s1_id;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [DATA_W-1:0]  r_resp_data;

    logic               w_grant_v;
    logic [IDW-1:0]     w_grant_id;
    logic [4:0]         w_grant_addr;
    logic [IDW-1:0]     w_next_ptr;
    logic [DATA_W-1:0]  w_sel_data;

    // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off < NUM_REQ
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned    off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + (IDW+1)'(off);
        if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
        end
        return sum[IDW-1:0];
    endfunction

    always_comb begin
        w_grant_v  = 1'b0;
        w_grant_id = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_v && req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_grant_v  = 1'b1;
                w_grant_id = wrap_idx(r_rr_ptr, k);
            end
        end
        if (port_block) begin
            w_grant_v = 1'b0;
        end
    end

    always_comb begin
        w_grant_addr = req_addr[5*int'(w_grant_id) +: 5];
        w_next_ptr   = wrap_idx(w_grant_id, 1);
        req_ready    = w_grant_v ? (NUM_REQ'(1) << w_grant_id) : '0;
    end

    // r0 is hard-wired zero and must never pick up a forwarded write
    always_comb begin
        if (r_s1_addr == 5'd0) begin
            w_sel_data = '0;
        end else if (wb_en && (wb_addr == r_s1_addr)) begin
            w_sel_data = wb_data;
        end else begin
            w_sel_data = rf_read_data;
        end
    end

    // s1_addr only moves on accept, so it doubles as the held decoder select
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_s1_v    <= 1'b0;
            r_s1_addr <= '0;
            r_s1_id   <= '0;
        end else begin
            r_s1_v <= w_grant_v;
            if (w_grant_v) begin
                r_s1_addr <= w_grant_addr;
                r_s1_id   <= w_grant_id;
                r_rr_ptr  <= w_next_ptr;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= r_s1_v ? (NUM_REQ'(1) << r_s1_id) : '0;
            if (r_s1_v) begin
                r_resp_data <= w_sel_data;
            end
        end
    end

    assign rf_read_addr = r_s1_addr;
    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: latency, rotation, r0/bypass rules, hold and reset.
module tb_regfile_read_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_addr = '0;
    logic [3:0]  req_ready;
    logic        port_block = 1'b0;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [3:0]  resp_valid;
    logic [31:0] resp_data;

    logic        use_model = 1'b0;
    logic [31:0] rf_manual = '0;

    int n_vec = 0;
    int n_err = 0;

    regfile_read_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .port_block   (port_block),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data)
    );

    // register-file stand-in: either a fixed pattern of the address or a forced value
    assign rf_read_data = use_model ? (32'hC0DE_0000 | {27'b0, rf_read_addr}) : rf_manual;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[5*i +: 5] = a;
    endtask

    initial begin
        // reset state
        #1 reset = 1'b1;
        #2;
        check("rst_ready", {28'b0, req_ready}, 32'h0);
        check("rst_rfaddr", {27'b0, rf_read_addr}, 32'h0);
        check("rst_rvalid", {28'b0, resp_valid}, 32'h0);
        check("rst_rdata", resp_data, 32'h0);
        tick();
        reset = 1'b0;

        // single read, two-edge latency
        req_valid = 4'b0001;
        set_addr(0, 5'd5);
        #2 check("t1_ready", {28'b0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        rf_manual = 32'hDEAD_BEEF;
        #2;
        check("t1_rfaddr", {27'b0, rf_read_addr}, 32'd5);
        check("t1_rvalid_early", {28'b0, resp_valid}, 32'h0);
        tick();
        check("t1_rvalid", {28'b0, resp_valid}, 32'h1);
        check("t1_rdata", resp_data, 32'hDEAD_BEEF);
        tick();
        check("t1_rvalid_off", {28'b0, resp_valid}, 32'h0);
        check("t1_rdata_hold", resp_data, 32'hDEAD_BEEF);

        // fairness: all four continuously valid from rr_ptr=0
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) set_addr(i, 5'(10 + i));
        use_model = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = '0;
            #2;
            if (k < 8)
                check($sformatf("rr_ready%0d", k), {28'b0, req_ready}, 32'h1 << (k % 4));
            else
                check($sformatf("rr_ready%0d", k), {28'b0, req_ready}, 32'h0);
            if (k >= 1)
                check($sformatf("rr_rfaddr%0d", k), {27'b0, rf_read_addr},
                      32'(10 + (((k - 1) > 7 ? 7 : (k - 1)) % 4)));
            if (k >= 2) begin
                check($sformatf("rr_rvalid%0d", k), {28'b0, resp_valid}, 32'h1 << ((k - 2) % 4));
                check($sformatf("rr_rdata%0d", k), resp_data, 32'hC0DE_0000 | 32'(10 + (k - 2) % 4));
            end
            tick();
        end
        use_model = 1'b0;

        // r0 reads as zero even with a writeback to r0 and rf driving ones
        req_valid = 4'b1000;
        set_addr(3, 5'd0);
        #2 check("r0_ready", {28'b0, req_ready}, 32'h8);
        tick();
        req_valid = '0;
        rf_manual = 32'hFFFF_FFFF;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h5555_5555;
        tick();
        check("r0_rvalid", {28'b0, resp_valid}, 32'h8);
        check("r0_rdata", resp_data, 32'h0);

        // bypass hit, address miss, enable off
        for (int v = 0; v < 3; v++) begin
            wb_en = 1'b0;
            req_valid = 4'b0001;
            set_addr(0, 5'd7);
            #2 check($sformatf("byp%0d_ready", v), {28'b0, req_ready}, 32'h1);
            tick();
            req_valid = '0;
            rf_manual = 32'hAAAA_AAAA;
            wb_data = 32'h1234_5678;
            wb_en = (v != 2);
            wb_addr = (v == 1) ? 5'd8 : 5'd7;
            tick();
            check($sformatf("byp%0d_rvalid", v), {28'b0, resp_valid}, 32'h1);
            check($sformatf("byp%0d_rdata", v), resp_data, (v == 0) ? 32'h1234_5678 : 32'hAAAA_AAAA);
        end
        wb_en = 1'b0;

        // port_block hold while an earlier read completes (rr_ptr=1 here)
        req_valid = 4'b1000;
        set_addr(3, 5'd3);
        #2 check("blk_pre_ready", {28'b0, req_ready}, 32'h8);
        tick();
        port_block = 1'b1;
        req_valid = 4'b0110;
        set_addr(1, 5'd17);
        set_addr(2, 5'd18);
        rf_manual = 32'h3333_3333;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("blk_ready%0d", c), {28'b0, req_ready}, 32'h0);
            check($sformatf("blk_rvalid%0d", c), {28'b0, resp_valid}, (c == 1) ? 32'h8 : 32'h0);
            tick();
        end
        check("blk_rdata", resp_data, 32'h3333_3333);
        port_block = 1'b0;
        #2 check("rel_ready1", {28'b0, req_ready}, 32'h2);
        tick();
        check("rel_ready2", {28'b0, req_ready}, 32'h4);
        check("rel_rfaddr1", {27'b0, rf_read_addr}, 32'd17);
        tick();
        req_valid = '0;
        rf_manual = 32'h4444_4444;
        #2;
        check("rel_rfaddr2", {27'b0, rf_read_addr}, 32'd18);
        check("rel_rvalid1", {28'b0, resp_valid}, 32'h2);
        tick();
        check("rel_rvalid2", {28'b0, resp_valid}, 32'h4);
        check("rel_rdata2", resp_data, 32'h4444_4444);

        // reset in the read cycle drops the request (rr_ptr=3 here)
        req_valid = 4'b0100;
        set_addr(2, 5'd9);
        #2 check("mid_ready", {28'b0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        #2 check("mid_rfaddr", {27'b0, rf_read_addr}, 32'd9);
        reset = 1'b1;
        #1;
        check("mid_rst_rfaddr", {27'b0, rf_read_addr}, 32'h0);
        check("mid_rst_rvalid", {28'b0, resp_valid}, 32'h0);
        check("mid_rst_rdata", resp_data, 32'h0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2 check($sformatf("mid_norsp%0d", c), {28'b0, resp_valid}, 32'h0);
            tick();
        end
        req_valid = 4'b1111;
        #2 check("mid_ptr0", {28'b0, req_ready}, 32'h1);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares the single register-file read port among NUM_REQ requesters (decode, branch unit, debug/display readout, multdiv) using round-robin arbitration.
- Drives the 5-bit read select that feeds the register file's read decoder.
- Registers the returned 32-bit data and routes it back to the winning requester.
- Forwards same-cycle writeback data and forces register 0 to read as zero.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); requester index width IDW = clog2(NUM_REQ).
- DATA_W, 32, register data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  5*NUM_REQ  register index; requester i uses bits [5i+4:5i].
- req_ready  out  NUM_REQ  one-hot grant, combinational; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- port_block  in  1  external hold (e.g. debug freeze); no grant is issued while it is 1.
- rf_read_addr  out  5  read select to the register-file decoder.
- rf_read_data  in  DATA_W  combinational register-file output for rf_read_addr.
- wb_en  in  1  writeback enable this cycle.
- wb_addr  in  5  writeback register index.
- wb_data  in  DATA_W  writeback data.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- resp_data  out  DATA_W  read result, valid when any resp_valid bit is 1.

Behaviour:
- Reset (async, active-high): rr_ptr=0; stage-1 valid s1_v=0; s1_addr=0; s1_id=0; resp_valid=0; resp_data=0; rf_read_addr=0. Requests in flight are dropped and never respond.
- Arbitration (cycle N, combinational):
  - Search requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first index with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - If port_block=1 or no request is valid, req_ready is all 0.
- On accept at the rising edge ending cycle N: s1_v<=1, s1_addr<=granted address, s1_id<=granted index, rr_ptr<=(granted+1) mod NUM_REQ.
- With no accept: s1_v<=0 and rr_ptr is unchanged.
- Read stage (cycle N+1): rf_read_addr=s1_addr (registered, so the decoder input is glitch-free). While s1_v=0, rf_read_addr holds its last value.
- Result selection in cycle N+1, in priority order:
  - s1_addr==0 -> 0.
  - else wb_en=1 and wb_addr==s1_addr -> wb_data (bypass).
  - else rf_read_data.
- Response (cycle N+2): resp_valid[s1_id] = 1 for exactly one cycle, and resp_data holds the selected value. resp_data holds its last value when no response is issued.
- Latency and throughput:
  - Accept-to-response is exactly 2 edges.
  - Full throughput: one accept per cycle with no bubbles.
  - Responses return in accept order.
- No backpressure on responses: the requester must sink resp_valid in the cycle it is asserted.
- A requester holding req_valid with req_ready=0 must keep req_addr stable. The arbiter does not check this.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...; each requester waits at most NUM_REQ-1 cycles.
- Simultaneous events:
  - port_block rising in the same cycle a request is valid -> no grant that cycle; the in-flight stage still completes.
  - A writeback to register 0 is never forwarded.
- Reset asserted mid-pipeline: all stage state clears immediately (asynchronously) and no resp_valid is produced for the dropped request.

Test Plan:
- Reset, then req_valid=0001 with addr 5, rf returns 0xDEADBEEF -> req_ready[0] in cycle 0; rf_read_addr=5 in cycle 1; resp_valid=0001 with resp_data=0xDEADBEEF in cycle 2.
- All four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one resp_valid per cycle, tagged in the same order.
- Read of addr 0 while rf_read_data=0xFFFFFFFF and wb_en=1, wb_addr=0 -> resp_data=0.
- Read of addr 7 with wb_en=1, wb_addr=7, wb_data=0x12345678 in the read cycle, rf_read_data=0xAAAAAAAA -> resp_data=0x12345678. Repeat with wb_addr=8 -> 0xAAAAAAAA.
- port_block=1 for 3 cycles while req_valid=0110 -> req_ready=0000 throughout. After release, requester 1 is granted first, then 2.
- Accept addr 9 from requester 2, then assert reset during cycle N+1 -> all outputs are 0 immediately, no resp_valid follows, and rr_ptr=0 after deassertion.
